mac_stream_feeder: RTL and testbench

- Transmit-side sequencer for the Stream_multiply_add MAC.
- A host loads pairs of signed operands into an internal buffer, then issues start.
- The block clears the MAC accumulator and streams one operand pair per cycle on stream_a/stream_b.
- It waits out the MAC latency, captures the MAC result, and reports it as a dot product with a one-cycle valid pulse.

---
 rtl/mac_stream_feeder.sv | 187 ++++++++++++++++++
 tb/tb_mac_stream_feeder.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/mac_stream_feeder.sv
// mac_stream_feeder
//   Transmit-side sequencer for a streaming multiply-accumulate unit. The host
//   fills an operand-pair buffer while the block is idle, then pulses start.
//   The block clears the MAC, streams one pair per cycle, waits out the MAC
//   latency, and captures the accumulator as the dot product.
//
// Ports
//   clk, reset_n            clock, asynchronous active-low reset
//   wr_en, wr_a, wr_b       push one signed operand pair (IDLE only)
//   buf_clr                 empty the buffer (IDLE only)
//   start, vec_len          run a dot product over the first vec_len entries
//   stream_a, stream_b      registered operands to the MAC (0 outside STREAM)
//   mac_clr_n               registered active-low clear for the MAC
//   mac_result              MAC accumulator output
//   dot_out, dot_valid      captured result and its one-cycle strobe
//   busy                    FSM not in IDLE
//   buf_count               valid buffer entries
//   err                     one-cycle pulse on a rejected request
//   chk_fail, ovf           only with MAC_FEED_CHECK_EN: shadow-sum mismatch
//                           and signed overflow of the true dot product
//
// Optional build macro: MAC_FEED_CHECK_EN (adds the shadow accumulator).
module mac_stream_feeder #(
    parameter int DATA_W  = 8,
    parameter int RES_W   = 16,
    parameter int DEPTH   = 16,
    parameter int MAC_LAT = 1
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic                     wr_en,
    input  logic [DATA_W-1:0]        wr_a,
    input  logic [DATA_W-1:0]        wr_b,
    input  logic                     buf_clr,
    input  logic                     start,
    input  logic [$clog2(DEPTH):0]   vec_len,
    output logic [DATA_W-1:0]        stream_a,
    output logic [DATA_W-1:0]        stream_b,
    output logic                     mac_clr_n,
    input  logic [RES_W-1:0]         mac_result,
    output logic [RES_W-1:0]         dot_out,
    output logic                     dot_valid,
    output logic                     busy,
    output logic [$clog2(DEPTH):0]   buf_count,
`ifdef MAC_FEED_CHECK_EN
    output logic                     chk_fail,
    output logic                     ovf,
`endif
    output logic                     err
);
    localparam int AW  = $clog2(DEPTH);
    localparam int LW  = AW + 1;
    localparam int DRW = (MAC_LAT > 2) ? $clog2(MAC_LAT) : 1;
    // DRAIN lasts MAC_LAT-1 cycles: count down from MAC_LAT-2 to 0.
    localparam logic [DRW-1:0] DRAIN_INIT = DRW'((MAC_LAT > 1) ? MAC_LAT - 2 : 0);

    typedef enum logic [2:0] {IDLE, CLEAR, STREAM, DRAIN, CAPTURE} state_t;

    state_t              r_state, w_nxt;
    logic [2*DATA_W-1:0] r_mem [DEPTH];
    logic [LW-1:0]       r_count, r_len, r_rd_ptr;
    logic [DRW-1:0]      r_drain;
    logic                r_zero;
    logic [DATA_W-1:0]   r_stream_a, r_stream_b;
    logic                r_mac_clr_n, r_dot_valid, r_err;
    logic [RES_W-1:0]    r_dot_out;
    logic                w_idle, w_accept, w_start_err, w_wr_ok, w_err, w_clr;

    assign w_idle = (r_state == IDLE);

    // start is resolved first; a write or clear in the same cycle is dropped.
    assign w_clr   = w_idle && !start && buf_clr;
    assign w_wr_ok = w_idle && !start && !buf_clr && wr_en && (r_count < LW'(DEPTH));
    assign w_err   = w_start_err
                   || (wr_en && (!w_idle || start || (!buf_clr && r_count == LW'(DEPTH))))
                   || (buf_clr && w_idle && start);

    always_comb begin
        w_nxt       = r_state;
        w_accept    = 1'b0;
        w_start_err = 1'b0;
        case (r_state)
            IDLE: if (start) begin
                if (vec_len > r_count) begin
                    w_start_err = 1'b1;
                end else begin
                    w_accept = 1'b1;
                    w_nxt    = (vec_len == '0) ? CAPTURE : CLEAR;
                end
            end
            CLEAR:   w_nxt = STREAM;
            // r_rd_ptr is one past the pair on the bus, so equality means
            // the last pair is being presented this cycle.
            STREAM:  if (r_rd_ptr == r_len) w_nxt = (MAC_LAT > 1) ? DRAIN : CAPTURE;
            DRAIN:   if (r_drain == '0) w_nxt = CAPTURE;
            CAPTURE: w_nxt = IDLE;
            default: w_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= IDLE;
            r_count     <= '0;
            r_len       <= '0;
            r_rd_ptr    <= '0;
            r_drain     <= '0;
            r_zero      <= 1'b0;
            r_stream_a  <= '0;
            r_stream_b  <= '0;
            r_mac_clr_n <= 1'b0;
            r_dot_out   <= '0;
            r_dot_valid <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_state     <= w_nxt;
            r_err       <= w_err;
            r_dot_valid <= (r_state == CAPTURE);

            if (w_clr)        r_count <= '0;
            else if (w_wr_ok) r_count <= r_count + 1'b1;

            if (w_accept) begin
                r_len    <= vec_len;
                r_rd_ptr <= '0;
                r_zero   <= (vec_len == '0);
            end

            r_stream_a <= '0;
            r_stream_b <= '0;
            if (w_nxt == STREAM) begin
                {r_stream_a, r_stream_b} <= r_mem[r_rd_ptr[AW-1:0]];
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end

            if (w_nxt == CLEAR)       r_mac_clr_n <= 1'b0;
            else if (w_nxt == STREAM) r_mac_clr_n <= 1'b1;

            if (w_nxt == DRAIN && r_state != DRAIN) r_drain <= DRAIN_INIT;
            else if (r_state == DRAIN)              r_drain <= r_drain - 1'b1;

            if (r_state == CAPTURE) r_dot_out <= r_zero ? '0 : mac_result;
        end
    end

    // Buffer storage needs no reset; only r_count defines what is valid.
    always_ff @(posedge clk) begin
        if (w_wr_ok) r_mem[r_count[AW-1:0]] <= {wr_a, wr_b};
    end

`ifdef MAC_FEED_CHECK_EN
    localparam int SW = 2*DATA_W + AW;
    logic signed [SW-1:0]       r_shadow;
    logic signed [2*DATA_W-1:0] w_prod;
    logic [RES_W-1:0]           w_cap;
    logic                       r_chk_fail, r_ovf;

    assign w_prod = $signed(r_stream_a) * $signed(r_stream_b);
    assign w_cap  = r_zero ? '0 : mac_result;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_shadow   <= '0;
            r_chk_fail <= 1'b0;
            r_ovf      <= 1'b0;
        end else begin
            if (w_accept)               r_shadow <= '0;
            else if (r_state == STREAM) r_shadow <= r_shadow + w_prod;
            r_chk_fail <= (r_state == CAPTURE) && (w_cap != r_shadow[RES_W-1:0]);
            r_ovf      <= (r_state == CAPTURE) &&
                          (r_shadow != SW'($signed(r_shadow[RES_W-1:0])));
        end
    end

    assign chk_fail = r_chk_fail;
    assign ovf      = r_ovf;
`endif

    assign stream_a  = r_stream_a;
    assign stream_b  = r_stream_b;
    assign mac_clr_n = r_mac_clr_n;
    assign dot_out   = r_dot_out;
    assign dot_valid = r_dot_valid;
    assign busy      = !w_idle;
    assign buf_count = r_count;
    assign err       = r_err;
endmodule

// File: tb/tb_mac_stream_feeder.sv
module tb_mac_stream_feeder;
    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic              wr_en = 1'b0, buf_clr = 1'b0, start = 1'b0;
    logic [7:0]        wr_a = '0, wr_b = '0;
    logic [4:0]        vec_len = '0;

    logic signed [7:0]  sa1, sb1, sa3, sb3;
    logic signed [15:0] dot1, dot3, acc1, acc3, d3a, d3b;
    logic               clrn1, clrn3, dv1, dv3, busy1, busy3, err1, err3;
    logic [4:0]         cnt1, cnt3;

    int n_vec = 0, n_err = 0;
    int bm_a[16], bm_b[16];

    always #5 clk = ~clk;

    mac_stream_feeder #(.DATA_W(8), .RES_W(16), .DEPTH(16), .MAC_LAT(1)) u1 (
        .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .wr_a(wr_a), .wr_b(wr_b),
        .buf_clr(buf_clr), .start(start), .vec_len(vec_len),
        .stream_a(sa1), .stream_b(sb1), .mac_clr_n(clrn1), .mac_result(acc1),
        .dot_out(dot1), .dot_valid(dv1), .busy(busy1), .buf_count(cnt1), .err(err1));

    mac_stream_feeder #(.DATA_W(8), .RES_W(16), .DEPTH(16), .MAC_LAT(3)) u3 (
        .clk(clk), .reset_n(reset_n), .wr_en(wr_en), .wr_a(wr_a), .wr_b(wr_b),
        .buf_clr(buf_clr), .start(start), .vec_len(vec_len),
        .stream_a(sa3), .stream_b(sb3), .mac_clr_n(clrn3), .mac_result(d3b),
        .dot_out(dot3), .dot_valid(dv3), .busy(busy3), .buf_count(cnt3), .err(err3));

    // MAC models: accumulate on each edge, async clear; the second one adds
    // two output register stages to give a latency of 3.
    always @(posedge clk or negedge clrn1)
        if (!clrn1) acc1 <= '0; else acc1 <= acc1 + sa1 * sb1;
    always @(posedge clk or negedge clrn3)
        if (!clrn3) acc3 <= '0; else acc3 <= acc3 + sa3 * sb3;
    always @(posedge clk) begin
        d3a <= acc3;
        d3b <= d3a;
    end

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic wr(input int a, input int b);
        wr_en = 1'b1; wr_a = 8'(a); wr_b = 8'(b);
        step();
        wr_en = 1'b0;
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 60 && (busy1 || busy3); i++) step();
        if (busy1 || busy3) chk("idle_timeout", 1, 0);
    endtask

    // Issue start and watch both instances; cycle 1 is the cycle after the
    // edge that samples start.
    task automatic run(input string nm, input int len, input int exp_dot,
                       input int exp_err, input int c1, input int c3);
        int got1 = -1, got3 = -1, v1 = 0, v3 = 0, lows = 0, errs = 0, sbad = 0, bz = 0;
        wait_idle();
        vec_len = 5'(len); start = 1'b1;
        step();
        start = 1'b0;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            if (err1) errs++;
            if (!clrn1) lows++;
            if (exp_err == 0 && cyc >= 2 && cyc <= len + 1)
                if (int'(sa1) != bm_a[cyc-2] || int'(sb1) != bm_b[cyc-2]) sbad++;
            if (dv1 && got1 < 0) begin got1 = cyc; v1 = int'(dot1); bz = busy1; end
            if (dv3 && got3 < 0) begin got3 = cyc; v3 = int'(dot3); end
            if ((got1 >= 0 && got3 >= 0) || (exp_err != 0 && cyc >= 3)) break;
            step();
        end
        if (exp_err != 0) begin
            chk({nm, "_err"}, errs, 1);
            chk({nm, "_novalid"}, got1, -1);
            chk({nm, "_clrlow"}, lows, 0);
            chk({nm, "_busy"}, busy1, 0);
        end else begin
            chk({nm, "_cyc1"}, got1, c1);
            chk({nm, "_cyc3"}, got3, c3);
            chk({nm, "_dot1"}, v1, exp_dot);
            chk({nm, "_dot3"}, v3, exp_dot);
            chk({nm, "_clrlow"}, lows, (len == 0) ? 0 : 1);
            chk({nm, "_stream"}, sbad, 0);
            chk({nm, "_err"}, errs, 0);
            chk({nm, "_busy_after"}, bz, 0);
        end
    endtask

    typedef struct {
        int len; int dot; int err; int c1; int c3;
    } vec_t;
    vec_t tbl[6];

    initial begin
        // {len, dot, err, cycle MAC_LAT=1, cycle MAC_LAT=3} over (2,3),(1,4),(-1,2),(0,0)
        tbl[0] = '{4,  8, 0, 7, 9};
        tbl[1] = '{3,  8, 0, 6, 8};
        tbl[2] = '{5,  0, 1, 0, 0};
        tbl[3] = '{0,  0, 0, 2, 2};
        tbl[4] = '{1,  6, 0, 4, 6};
        tbl[5] = '{2, 10, 0, 5, 7};

        step(); step();
        chk("rst_stream_a", int'(sa1), 0);
        chk("rst_stream_b", int'(sb1), 0);
        chk("rst_mac_clr_n", clrn1, 0);
        chk("rst_dot_out", int'(dot1), 0);
        chk("rst_dot_valid", dv1, 0);
        chk("rst_busy", busy1, 0);
        chk("rst_err", err1, 0);
        chk("rst_buf_count", cnt1, 0);
        @(negedge clk) reset_n = 1'b1;
        step();

        bm_a[0] = 2;  bm_b[0] = 3;
        bm_a[1] = 1;  bm_b[1] = 4;
        bm_a[2] = -1; bm_b[2] = 2;
        bm_a[3] = 0;  bm_b[3] = 0;
        for (int i = 0; i < 4; i++) wr(bm_a[i], bm_b[i]);
        chk("load4_count", cnt1, 4);

        for (int i = 0; i < 6; i++) begin
            run($sformatf("vec%0d", i), tbl[i].len, tbl[i].dot, tbl[i].err, tbl[i].c1, tbl[i].c3);
            chk($sformatf("vec%0d_count", i), cnt1, 4);
        end

        // Full buffer of extremes; the 17th write is rejected.
        wait_idle();
        buf_clr = 1'b1; step(); buf_clr = 1'b0;
        chk("clr_count", cnt1, 0);
        for (int i = 0; i < 16; i++) begin
            bm_a[i] = -128; bm_b[i] = -128;
            wr(-128, -128);
        end
        chk("full_count", cnt1, 16);
        wr(1, 1);
        chk("full_wr_err", err1, 1);
        chk("full_wr_count", cnt1, 16);
        run("full16", 16, 0, 0, 19, 21);

        // start and wr_en together: start wins, write dropped with err.
        vec_len = 5'd1; start = 1'b1; wr_en = 1'b1; wr_a = 8'd7; wr_b = 8'd7;
        step();
        start = 1'b0; wr_en = 1'b0;
        chk("start_wr_err", err1, 1);
        chk("start_wr_busy", busy1, 1);
        start = 1'b1;   // ignored while busy, no err
        step();
        start = 1'b0;
        chk("busy_start_noerr", err1, 0);
        wait_idle();
        chk("start_wr_dot", int'(dot1), 16384);
        chk("start_wr_count", cnt1, 16);
        chk("start_wr_count3", cnt3, 16);

        // buf_clr beats wr_en in the same cycle.
        buf_clr = 1'b1; wr_en = 1'b1;
        step();
        buf_clr = 1'b0; wr_en = 1'b0;
        chk("clr_wr_count", cnt1, 0);
        chk("clr_wr_noerr", err3, 0);

        // Latency-3 case: (3,3),(2,-2).
        bm_a[0] = 3; bm_b[0] = 3;
        bm_a[1] = 2; bm_b[1] = -2;
        wr(3, 3); wr(2, -2);
        run("lat3", 2, 5, 0, 5, 7);

        // Reset on the second STREAM cycle.
        wait_idle();
        vec_len = 5'd2; start = 1'b1;
        step();          // cycle 1: CLEAR
        start = 1'b0;
        step();          // cycle 2: first STREAM
        step();          // cycle 3: second STREAM
        chk("mid_stream_a", int'(sa1), 2);
        reset_n = 1'b0;
        #1;
        chk("midrst_stream_a", int'(sa1), 0);
        chk("midrst_mac_clr_n", clrn1, 0);
        chk("midrst_busy", busy1, 0);
        chk("midrst_count", cnt1, 0);
        @(negedge clk) reset_n = 1'b1;
        step();
        bm_a[0] = 5; bm_b[0] = 5;
        wr(5, 5);
        run("after_rst", 1, 25, 0, 4, 6);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
